flash_sample_prefetch: RTL and testbench

Prefetch buffer between the flash reader and the audio-codec write sequencer. It pulls 16-bit signed samples from the flash reader's valid/next/done interface into a small FIFO and applies a programmable attenuation on entry. It presents the samples to the codec-side state machine through a valid/take handshake. This keeps flash read latency off the codec's write_ready critical window, and the block counts underruns for debug.

---
 rtl/flash_sample_prefetch.sv | 120 ++++++++++++
 tb/tb_flash_sample_prefetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_prefetch.sv
`default_nettype none
//==============================================================================
// flash_sample_prefetch
// Prefetch FIFO between the flash reader and the codec write sequencer:
// attenuates samples on entry and counts consumer underruns.
// Revision: 1.0
//==============================================================================
module flash_sample_prefetch #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] fr_data,
    input  logic        fr_valid,
    input  logic        fr_done,
    output logic        fr_next,
    input  logic [1:0]  gain_shift,
    output logic [15:0] smp_data,
    output logic        smp_valid,
    input  logic        smp_take,
    output logic        smp_end,
    output logic [15:0] underrun_cnt
);

    localparam logic [1:0]  F_IDLE  = 2'd0;
    localparam logic [1:0]  F_DRAIN = 2'd1;
    localparam logic [1:0]  F_END   = 2'd2;
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               fetch;
    logic [15:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               push;
    logic               pop;
    logic signed [15:0] fr_data_s;
    logic signed [15:0] sample;

    // The word is written during the fr_next cycle, while the reader still
    // holds it, so it appears on smp_data the cycle after fr_next.
    assign push      = fr_next;
    assign pop       = smp_take && (count != '0);
    assign fr_data_s = fr_data;
    assign sample    = fr_data_s >>> gain_shift;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= F_IDLE;
            fr_next <= 1'b0;
        end else begin
            state   <= state_nx;
            fr_next <= fetch;
        end
    end

    always_comb begin
        state_nx = state;
        fetch    = 1'b0;
        case (state)
            F_IDLE: begin
                if (fr_valid && fr_done) begin
                    state_nx = F_END;
                end else if (fr_valid && (count != FULL)) begin
                    state_nx = F_DRAIN;
                    fetch    = 1'b1;
                end
            end
            F_DRAIN: begin
                if (!fr_valid) begin
                    state_nx = F_IDLE;
                end
            end
            F_END:   state_nx = F_END;
            default: state_nx = F_IDLE;
        endcase
    end

    always_comb begin
        smp_valid = (count != '0);
        smp_data  = smp_valid ? mem[rd_ptr] : 16'h0000;
        smp_end   = (state == F_END) && (count == '0);
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            underrun_cnt <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (smp_take && (count == '0) && (state != F_END) &&
                (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_prefetch.sv
`default_nettype none
//==============================================================================
// tb_flash_sample_prefetch
// Self-checking bench: flash reader model plus a queue-based sample scoreboard.
// Revision: 1.0
//==============================================================================
module tb_flash_sample_prefetch;

    localparam int DEPTH = 8;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [15:0] fr_data;
    logic        fr_valid;
    logic        fr_done;
    logic        fr_next;
    logic [1:0]  gain_shift;
    logic [15:0] smp_data;
    logic        smp_valid;
    logic        smp_take;
    logic        smp_end;
    logic [15:0] underrun_cnt;

    flash_sample_prefetch #(.DEPTH(DEPTH)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .fr_data      (fr_data),
        .fr_valid     (fr_valid),
        .fr_done      (fr_done),
        .fr_next      (fr_next),
        .gain_shift   (gain_shift),
        .smp_data     (smp_data),
        .smp_valid    (smp_valid),
        .smp_take     (smp_take),
        .smp_end      (smp_end),
        .underrun_cnt (underrun_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_pass  = 0;
    int n_total = 0;

    // scoreboard: samples the FIFO should hold, oldest first
    logic [15:0] mq[$];
    int          m_und  = 0;
    bit          m_end  = 0;
    int          n_next = 0;
    int          n_pop  = 0;
    bit          mon_en = 0;

    // flash reader model
    logic [15:0] src_q[$];
    bit          src_end  = 0;
    bit          rd_en    = 0;
    int          gap      = 0;
    int          drop_len = 2;

    typedef struct {
        logic [1:0]  g;
        logic [15:0] w;
        logic [15:0] exp;
    } vec_t;
    vec_t vec[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // floor(w / 2^g) on the signed value
    function automatic logic [15:0] att(input logic [15:0] w, input logic [1:0] g);
        int v, d, q;
        v = int'($signed(w));
        d = 1 << g;
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        return q[15:0];
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        smp_take = 1'b0;
        src_q.delete();
        src_end  = 0;
        repeat (2) tick();
        reset    = 1'b0;
    endtask

    // Monitor, scoreboard update and reader, all on the falling edge.
    initial begin
        fr_valid = 1'b0;
        fr_done  = 1'b0;
        fr_data  = 16'h0000;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                mq.delete();
                m_und    = 0;
                m_end    = 0;
                gap      = 0;
                fr_valid = 1'b0;
                fr_done  = 1'b0;
            end else begin
                if (mon_en) begin
                    check("smp_valid", smp_valid, mq.size() != 0);
                    check("smp_data", smp_data, (mq.size() != 0) ? mq[0] : 16'h0000);
                    check("smp_end", smp_end, m_end && (mq.size() == 0));
                    check("underrun_cnt", underrun_cnt, m_und);
                end
                if (fr_next) begin
                    n_next++;
                    check("fr_next_on_word", {fr_valid, fr_done}, 2'b10);
                end
                if (smp_take) begin
                    if (mq.size() != 0) begin
                        void'(mq.pop_front());
                        n_pop++;
                    end else if (!m_end && m_und < 65535) begin
                        m_und++;
                    end
                end
                if (fr_next) begin
                    mq.push_back(att(fr_data, gain_shift));
                    check("occupancy_le_depth", mq.size() <= DEPTH, 1);
                end
                if (fr_valid && fr_done) m_end = 1;

                if (!rd_en) begin
                    fr_valid = 1'b0;
                    fr_done  = 1'b0;
                end else if (fr_valid && fr_next) begin
                    if (src_q.size() != 0) void'(src_q.pop_front());
                    gap = drop_len;
                end else if (gap > 0) begin
                    fr_valid = 1'b0;
                    fr_done  = 1'b0;
                    gap--;
                end else if (src_q.size() != 0) begin
                    fr_valid = 1'b1;
                    fr_done  = 1'b0;
                    fr_data  = src_q[0];
                end else if (src_end) begin
                    fr_valid = 1'b1;
                    fr_done  = 1'b1;
                    fr_data  = 16'hDEAD;
                end else begin
                    fr_valid = 1'b0;
                    fr_done  = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [15:0] first_w;
        logic [1:0]  first_g;

        vec[0] = '{2'd0, 16'h1234, 16'h1234};
        vec[1] = '{2'd2, 16'h8000, 16'hE000};
        vec[2] = '{2'd2, 16'h7FFF, 16'h1FFF};
        vec[3] = '{2'd1, 16'hFFFF, 16'hFFFF};
        vec[4] = '{2'd3, 16'h8000, 16'hF000};
        vec[5] = '{2'd3, 16'h0007, 16'h0000};
        vec[6] = '{2'd1, 16'h0003, 16'h0001};
        vec[7] = '{2'd3, 16'hFFF8, 16'hFFFF};

        reset      = 1'b1;
        smp_take   = 1'b0;
        gain_shift = 2'd0;
        repeat (2) tick();
        check("rst_fr_next", fr_next, 0);
        check("rst_smp_valid", smp_valid, 0);
        check("rst_smp_data", smp_data, 0);
        check("rst_smp_end", smp_end, 0);
        check("rst_underrun", underrun_cnt, 0);
        reset  = 1'b0;
        rd_en  = 1;
        mon_en = 1;
        tick();

        // underrun before any data
        smp_take = 1'b1;
        repeat (5) tick();
        smp_take = 1'b0;
        tick();
        check("underrun_5", underrun_cnt, 5);
        check("underrun_data", smp_data, 0);

        // basic fill: stalls at DEPTH with two words pending
        n_next = 0;
        n_pop  = 0;
        for (int i = 1; i <= 10; i++) src_q.push_back(16'(i));
        repeat (100) tick();
        check("fill_next_pulses", n_next, 8);
        check("fill_valid", smp_valid, 1);
        check("fill_head", smp_data, 16'h0001);
        check("fill_pending", src_q.size(), 2);
        check("fill_stalled", fr_next, 0);

        // drain with smp_take held high
        smp_take = 1'b1;
        for (int t = 0; t < 300 && (src_q.size() != 0 || mq.size() != 0); t++) tick();
        smp_take = 1'b0;
        check("drain_timeout", (src_q.size() == 0) && (mq.size() == 0), 1);
        tick();
        check("drain_pops", n_pop, 10);

        // attenuation vectors
        for (int i = 0; i < 8; i++) begin
            gain_shift = vec[i].g;
            src_q.push_back(vec[i].w);
            for (int t = 0; t < 50 && !smp_valid; t++) tick();
            check("att_timeout", smp_valid, 1);
            gain_shift = ~vec[i].g;
            tick();
            check("att_value", smp_data, vec[i].exp);
            smp_take = 1'b1;
            tick();
            smp_take = 1'b0;
        end

        // 20 words, take every third cycle
        n_pop = 0;
        for (int i = 0; i < 20; i++) src_q.push_back(16'($urandom));
        for (int c = 0; c < 600 && (src_q.size() != 0 || mq.size() != 0); c++) begin
            smp_take   = (c % 3 == 0);
            gain_shift = 2'($urandom);
            tick();
        end
        smp_take = 1'b0;
        check("stream20_timeout", (src_q.size() == 0) && (mq.size() == 0), 1);
        check("stream20_pops", n_pop, 20);

        // random phase: slow consumer first (fills), then fast
        n_pop    = 0;
        drop_len = 1;
        for (int i = 0; i < 60; i++) src_q.push_back(16'($urandom));
        for (int c = 0; c < 2000 && (src_q.size() != 0 || mq.size() != 0); c++) begin
            smp_take   = (c < 200) ? ($urandom_range(7) == 0) : ($urandom_range(1) == 0);
            gain_shift = 2'($urandom);
            tick();
        end
        smp_take = 1'b0;
        drop_len = 2;
        check("random_timeout", (src_q.size() == 0) && (mq.size() == 0), 1);
        check("random_pops", n_pop, 60);

        // end of stream
        do_reset();
        n_next     = 0;
        gain_shift = 2'd0;
        for (int i = 0; i < 3; i++) src_q.push_back(16'h0100 + 16'(i));
        src_end = 1;
        for (int t = 0; t < 100 && !m_end; t++) tick();
        check("eos_timeout", m_end, 1);
        repeat (20) tick();
        check("eos_next_pulses", n_next, 3);
        check("eos_not_yet", smp_end, 0);
        for (int k = 0; k < 3; k++) begin
            smp_take = 1'b1;
            tick();
            smp_take = 1'b0;
            check("eos_after_pop", smp_end, k == 2);
        end
        smp_take = 1'b1;
        repeat (5) tick();
        smp_take = 1'b0;
        tick();
        check("eos_underrun_frozen", underrun_cnt, 0);
        check("eos_sticky", smp_end, 1);
        check("eos_no_fetch", n_next, 3);

        // saturation
        do_reset();
        smp_take = 1'b1;
        repeat (70000) tick();
        smp_take = 1'b0;
        tick();
        check("underrun_saturate", underrun_cnt, 16'hFFFF);

        // reset mid-operation with 5 buffered and fr_next high
        do_reset();
        gain_shift = 2'd1;
        for (int i = 0; i < 10; i++) src_q.push_back(16'hA000 + 16'(i));
        for (int t = 0; t < 200 && !(mq.size() == 5 && fr_next); t++) tick();
        check("midrst_timeout", (mq.size() == 5) && fr_next, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_fr_next", fr_next, 0);
        check("midrst_smp_valid", smp_valid, 0);
        check("midrst_smp_data", smp_data, 0);
        check("midrst_smp_end", smp_end, 0);
        check("midrst_underrun", underrun_cnt, 0);
        repeat (2) tick();
        first_w = src_q[0];
        first_g = gain_shift;
        reset   = 1'b0;
        for (int t = 0; t < 100 && !smp_valid; t++) tick();
        check("midrst_restart", smp_valid, 1);
        check("midrst_first", smp_data, att(first_w, first_g));

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
